// File: rtl/ext_ram_pkg.sv
// Shared types and widths for the external SRAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ext_ram_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Access sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RD_ACCESS,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  // Requester identifier: 0 = port 0, 1 = port 1
  typedef logic port_id_t;

  // Fields latched from the winning requester
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be_n;
  } req_t;

  // Wait-counter load value for a strobe held low for 'cycles' cycles
  function automatic logic [3:0] wait_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/ext_ram_rr_picker.sv
// Two-way request picker; tie policy set by EXT_RAM_ROUND_ROBIN_EN (pointer picks tie winner) else port 0.
// Latency: combinational, zero cycles.
// Backpressure: none; the loser simply stays unselected while its request is held.
module ext_ram_rr_picker
  import ext_ram_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  port_id_t   ptr,
  output logic [1:0] grant
);

  // One-hot grant; on a tie the configured policy decides
  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
`ifdef EXT_RAM_ROUND_ROBIN_EN
      grant = (ptr == 1'b1) ? 2'b10 : 2'b01;
`else
      grant = 2'b01;
`endif
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

`ifndef EXT_RAM_ROUND_ROBIN_EN
  // Fixed priority ignores the pointer
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/ext_ram_arbiter.sv
// Two-port arbiter sequencing async SRAM reads/writes; tie policy via EXT_RAM_ROUND_ROBIN_EN.
// Latency: ack RD_WAIT+1 (read) / WR_WAIT+3 (write) cycles after the sampling cycle.
// Backpressure: requester holds req and fields until its one-cycle ack; loser keeps waiting.
module ext_ram_arbiter
  import ext_ram_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [BE_W-1:0]   p0_be_n,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [BE_W-1:0]   p1_be_n,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] ext_ram_data,
  output logic [ADDR_W-1:0] ext_ram_addr,
  output logic [BE_W-1:0]   ext_ram_be_n,
  output logic              ext_ram_ce_n,
  output logic              ext_ram_oe_n,
  output logic              ext_ram_we_n
);

  localparam logic [3:0] RD_LOAD = wait_load(RD_WAIT);
  localparam logic [3:0] WR_LOAD = wait_load(WR_WAIT);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        cnt_q;
  req_t              cur_q;
  port_id_t          winner_q;
  port_id_t          ptr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        grant;
  port_id_t          grant_id;
  req_t              grant_req;
  logic              drive;

  ext_ram_rr_picker u_picker (
    .req0  (p0_req),
    .req1  (p1_req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Identify the winner and select its request fields
  always_comb begin
    grant_id  = port_id_t'(grant[1]);
    grant_req = grant[1] ? '{we: p1_we, addr: p1_addr, wdata: p1_wdata, be_n: p1_be_n}
                         : '{we: p0_we, addr: p0_addr, wdata: p0_wdata, be_n: p0_be_n};
  end

  // Next-state sequencing of the SRAM access
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant != 2'b00) state_d = grant_req.we ? WR_SETUP : RD_ACCESS;
      RD_ACCESS: if (cnt_q == 4'd0) state_d = DONE;
      WR_SETUP:  state_d = WR_PULSE;
      WR_PULSE:  if (cnt_q == 4'd0) state_d = WR_HOLD;
      WR_HOLD:   state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Latch request on grant, run the wait counter, capture read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q    <= '{we: 1'b0, addr: '0, wdata: '0, be_n: '1};
      winner_q <= 1'b0;
      ptr_q    <= 1'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            cur_q    <= grant_req;
            winner_q <= grant_id;
            ptr_q    <= ~grant_id;
            cnt_q    <= grant_req.we ? WR_LOAD : RD_LOAD;
          end
        end
        RD_ACCESS: begin
          if (cnt_q == 4'd0) rdata_q <= ext_ram_data;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        WR_PULSE: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Strobes, bus enable and acks decoded from state so reset releases them at once
  always_comb begin
    ext_ram_ce_n = 1'b1;
    ext_ram_oe_n = 1'b1;
    ext_ram_we_n = 1'b1;
    drive        = 1'b0;
    p0_ack       = 1'b0;
    p1_ack       = 1'b0;
    unique case (state_q)
      RD_ACCESS: begin
        ext_ram_ce_n = 1'b0;
        ext_ram_oe_n = 1'b0;
      end
      WR_SETUP: begin
        ext_ram_ce_n = 1'b0;
        drive        = 1'b1;
      end
      WR_PULSE: begin
        ext_ram_ce_n = 1'b0;
        ext_ram_we_n = 1'b0;
        drive        = 1'b1;
      end
      WR_HOLD: begin
        ext_ram_ce_n = 1'b0;
        drive        = 1'b1;
      end
      DONE: begin
        p0_ack = (winner_q == 1'b0);
        p1_ack = (winner_q == 1'b1);
      end
      default: ;
    endcase
  end

  assign ext_ram_addr = cur_q.addr;
  assign ext_ram_be_n = cur_q.be_n;
  assign rdata        = rdata_q;
  assign ext_ram_data = drive ? cur_q.wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ext_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ext_ram_arbiter;

  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [19:0] p0_addr = '0;
  logic [31:0] p0_wdata = '0;
  logic [3:0]  p0_be_n = 4'hF;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [19:0] p1_addr = '0;
  logic [31:0] p1_wdata = '0;
  logic [3:0]  p1_be_n = 4'hF;
  logic        p0_ack, p1_ack;
  logic [31:0] rdata;
  wire  [31:0] ext_ram_data;
  logic [19:0] ext_ram_addr;
  logic [3:0]  ext_ram_be_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] mem [256];

  ext_ram_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be_n(p0_be_n),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be_n(p1_be_n),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .rdata(rdata),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
    .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: drives on read, writes enabled bytes while we_n is low
  assign ext_ram_data = (!ext_ram_ce_n && !ext_ram_oe_n) ? mem[ext_ram_addr[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!ext_ram_ce_n && !ext_ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!ext_ram_be_n[b]) mem[ext_ram_addr[7:0]][8*b +: 8] = ext_ram_data[8*b +: 8];
    end
  end

  // Scoreboard: every ack is matched against the oldest expected completion
  always @(negedge clk) begin
    if (rst) begin
      if (p0_ack && p1_ack) begin
        checks++; errors++;
        $display("FAIL dual_ack: both acks high, required at most one");
      end else if (p0_ack || p1_ack) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: port %0d acked, required no ack", p1_ack);
        end else begin
          mon_e = sb.pop_front();
          if (p1_ack !== mon_e.port) begin
            errors++;
            $display("FAIL ack_port: got port %0d, required port %0d", p1_ack, mon_e.port);
          end
          if (!mon_e.we) begin
            checks++;
            if (rdata !== mon_e.data) begin
              errors++;
              $display("FAIL ack_rdata: got %h, required %h", rdata, mon_e.data);
            end
          end
        end
      end
    end
  end

  task automatic drive_port(input logic port, input logic req, input logic we,
                            input logic [19:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (!port) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be_n = be;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be_n = be;
    end
  endtask

  // One transaction from an idle arbiter; k counts cycles after the sampling cycle
  task automatic run_one(input logic port, input logic we, input logic [19:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int ack_k, output int oe_low, output int we_low, output int drv);
    exp_t e;
    ack_k = 0; oe_low = 0; we_low = 0; drv = 0;
    @(negedge clk);
    e.port = port; e.we = we; e.data = we ? wdata : mem[addr[7:0]];
    sb.push_back(e);
    drive_port(port, 1'b1, we, addr, wdata, be);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!ext_ram_oe_n) oe_low++;
      if (!ext_ram_we_n) we_low++;
      if (ext_ram_oe_n && ext_ram_data === wdata) drv++;
      if (port ? p1_ack : p0_ack) begin
        ack_k = k;
        drive_port(port, 1'b0, we, addr, wdata, be);
        break;
      end
    end
    if (ack_k == 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack from port %0d within 30 cycles", port);
      drive_port(port, 1'b0, we, addr, wdata, be);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 6;
    if ({ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b, required 111", {ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n});
    end
    if (ext_ram_be_n !== 4'hF) begin errors++; $display("FAIL reset_be_n: got %h, required f", ext_ram_be_n); end
    if (ext_ram_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h, required 0", ext_ram_addr); end
    if (p0_ack !== 1'b0) begin errors++; $display("FAIL reset_p0_ack: got %b, required 0", p0_ack); end
    if (p1_ack !== 1'b0) begin errors++; $display("FAIL reset_p1_ack: got %b, required 0", p1_ack); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    int ack_k, oe_low, we_low, drv;
    mem[8'h10] = 32'hDEADBEEF;
    run_one(1'b0, 1'b0, 20'h00010, 32'h0, 4'h0, ack_k, oe_low, we_low, drv);
    checks += 3;
    if (ack_k != RD_WAIT + 1) begin errors++; $display("FAIL read_ack_latency: got %0d, required %0d", ack_k, RD_WAIT + 1); end
    if (oe_low != RD_WAIT) begin errors++; $display("FAIL read_oe_cycles: got %0d, required %0d", oe_low, RD_WAIT); end
    if (we_low != 0) begin errors++; $display("FAIL read_we_cycles: got %0d, required 0", we_low); end
  endtask

  task automatic test_write();
    int ack_k, oe_low, we_low, drv;
    mem[8'hFF] = 32'h0;
    run_one(1'b1, 1'b1, 20'hFFFFF, 32'h12345678, 4'b0000, ack_k, oe_low, we_low, drv);
    checks += 7;
    if (ack_k != WR_WAIT + 3) begin errors++; $display("FAIL write_ack_latency: got %0d, required %0d", ack_k, WR_WAIT + 3); end
    if (we_low != WR_WAIT) begin errors++; $display("FAIL write_we_cycles: got %0d, required %0d", we_low, WR_WAIT); end
    if (drv != WR_WAIT + 2) begin errors++; $display("FAIL write_bus_cycles: got %0d, required %0d", drv, WR_WAIT + 2); end
    if (oe_low != 0) begin errors++; $display("FAIL write_oe_cycles: got %0d, required 0", oe_low); end
    if (ext_ram_addr !== 20'hFFFFF) begin errors++; $display("FAIL write_addr_hold: got %h, required fffff", ext_ram_addr); end
    if (ext_ram_be_n !== 4'h0) begin errors++; $display("FAIL write_be_hold: got %h, required 0", ext_ram_be_n); end
    @(negedge clk);
    if (mem[8'hFF] !== 32'h12345678) begin errors++; $display("FAIL write_mem: got %h, required 12345678", mem[8'hFF]); end
  endtask

  task automatic test_tie();
    logic exp_port [5];
    int n = 0, guard = 0, p0_cnt = 0;
    logic got;
    exp_t e;
    mem[8'h20] = 32'hA0A00020;
    mem[8'h21] = 32'hB1B10021;
`ifdef EXT_RAM_ROUND_ROBIN_EN
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 5; i++) begin
      e.port = exp_port[i]; e.we = 1'b0; e.data = exp_port[i] ? mem[8'h21] : mem[8'h20];
      sb.push_back(e);
    end
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, 20'h00020, 32'h0, 4'h0);
    drive_port(1'b1, 1'b1, 1'b0, 20'h00021, 32'h0, 4'h0);
    while (n < 5 && guard < 200) begin
      @(negedge clk); guard++;
      if (p0_ack || p1_ack) begin
        got = p1_ack;
        n++;
        if (n <= 4 && !got) p0_cnt++;
        drive_port(got, 1'b0, 1'b0, got ? 20'h00021 : 20'h00020, 32'h0, 4'h0);
        if (n < 4) begin
          @(negedge clk); guard++;
          drive_port(got, 1'b1, 1'b0, got ? 20'h00021 : 20'h00020, 32'h0, 4'h0);
        end
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 20'h0, 32'h0, 4'hF);
    drive_port(1'b1, 1'b0, 1'b0, 20'h0, 32'h0, 4'hF);
    checks += 2;
    if (n != 5) begin errors++; $display("FAIL tie_ack_count: got %0d, required 5", n); end
`ifdef EXT_RAM_ROUND_ROBIN_EN
    if (p0_cnt != 2) begin errors++; $display("FAIL tie_p0_share: got %0d, required 2", p0_cnt); end
`else
    if (p0_cnt != 4) begin errors++; $display("FAIL tie_p0_share: got %0d, required 4", p0_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    int k1 = 0, k2 = 0;
    exp_t e;
    e.port = 1'b0; e.we = 1'b0; e.data = mem[8'h10];
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b0, 20'h00010, 32'h0, 4'h0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (p0_ack) begin
        if (k1 == 0) k1 = k;
        else begin
          k2 = k;
          break;
        end
      end
    end
    drive_port(1'b0, 1'b0, 1'b0, 20'h00010, 32'h0, 4'h0);
    checks += 2;
    if (k1 != RD_WAIT + 1) begin errors++; $display("FAIL b2b_first_ack: got %0d, required %0d", k1, RD_WAIT + 1); end
    if (k2 - k1 != RD_WAIT + 2) begin errors++; $display("FAIL b2b_ack_spacing: got %0d, required %0d", k2 - k1, RD_WAIT + 2); end
  endtask

  task automatic test_reset_mid_write();
    int seen = 0, late_acks = 0;
    int ack_k, oe_low, we_low, drv;
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, 20'h00030, 32'hCAFEF00D, 4'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!ext_ram_we_n) begin seen = 1; break; end
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL midrst_pulse_seen: we_n never low, required low"); end
    #1 rst = 1'b0;
    #1;
    checks += 6;
    if (ext_ram_we_n !== 1'b1) begin errors++; $display("FAIL midrst_we_n: got %b, required 1", ext_ram_we_n); end
    if (ext_ram_ce_n !== 1'b1) begin errors++; $display("FAIL midrst_ce_n: got %b, required 1", ext_ram_ce_n); end
    if (ext_ram_data === 32'hCAFEF00D) begin errors++; $display("FAIL midrst_bus: got %h, required released", ext_ram_data); end
    if (p0_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack: got %b, required 0", p0_ack); end
    if (ext_ram_addr !== 20'h0) begin errors++; $display("FAIL midrst_addr: got %h, required 0", ext_ram_addr); end
    if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h, required 0", rdata); end
    drive_port(1'b0, 1'b0, 1'b0, 20'h0, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (p0_ack || p1_ack) late_acks++;
    end
    checks++;
    if (late_acks != 0) begin errors++; $display("FAIL midrst_no_ack: got %0d acks, required 0", late_acks); end
    run_one(1'b0, 1'b0, 20'h00010, 32'h0, 4'h0, ack_k, oe_low, we_low, drv);
    checks += 2;
    if (ack_k != RD_WAIT + 1) begin errors++; $display("FAIL post_rst_read_latency: got %0d, required %0d", ack_k, RD_WAIT + 1); end
    if (oe_low != RD_WAIT) begin errors++; $display("FAIL post_rst_read_oe: got %0d, required %0d", oe_low, RD_WAIT); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_back_to_back();
    test_reset_mid_write();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected acks missing, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
